// File: rtl/fwd_operand_stage_if.sv
// Decode / producer-stage / execute-register bundle for the operand forwarding stage.
// The master side (decode, pipeline stages, bench) drives requests and stage results;
// the slave side (fwd_operand_stage) returns the handshake and the execute register.
interface fwd_operand_stage_if #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int SELW    = $clog2(DEPTH + 1)
);
   logic                      id_valid_i;
   logic                      id_ready_o;
   logic [NUM_SRC*REG_AW-1:0] id_rs_i;
   logic [NUM_SRC*DATA_W-1:0] id_rf_data_i;
   logic [REG_AW-1:0]         id_rd_i;
   logic                      id_we_i;
   logic [DEPTH*DATA_W-1:0]   stg_data_i;
   logic [DEPTH-1:0]          stg_ready_i;
   logic                      hold_i;
   logic                      ex_valid_o;
   logic [NUM_SRC*DATA_W-1:0] ex_op_o;
   logic [REG_AW-1:0]         ex_rd_o;
   logic                      ex_we_o;
   logic [NUM_SRC*SELW-1:0]   fwd_sel_o;
   logic [15:0]               hazard_cnt_o;

   modport master (
      output id_valid_i, id_rs_i, id_rf_data_i, id_rd_i, id_we_i,
             stg_data_i, stg_ready_i, hold_i,
      input  id_ready_o, ex_valid_o, ex_op_o, ex_rd_o, ex_we_o,
             fwd_sel_o, hazard_cnt_o
   );

   modport slave (
      input  id_valid_i, id_rs_i, id_rf_data_i, id_rd_i, id_we_i,
             stg_data_i, stg_ready_i, hold_i,
      output id_ready_o, ex_valid_o, ex_op_o, ex_rd_o, ex_we_o,
             fwd_sel_o, hazard_cnt_o
   );
endinterface

// File: rtl/fwd_operand_stage.sv
// Operand forwarding stage on the decode-to-execute boundary. A shift-register
// scoreboard remembers {valid, we, rd} of the last DEPTH issued instructions
// (entry 0 = EX, then MEM, WB). Each source takes the youngest matching producer's
// result, or the register file when nothing in flight writes it. A match whose
// result is not yet final stalls decode; every stalled edge bumps a saturating counter.
module fwd_operand_stage #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int SELW    = $clog2(DEPTH + 1)
) (
   input logic                clk_i,
   input logic                rst_i,
   fwd_operand_stage_if.slave bus
);

   // scoreboard, index 0 is the youngest entry (mirrors the execute register)
   logic [DEPTH-1:0]          sb_valid_r;
   logic [DEPTH-1:0]          sb_we_r;
   logic [REG_AW-1:0]         sb_rd_r [DEPTH];

   // per-source resolution
   logic [REG_AW-1:0]         rs_s    [NUM_SRC];
   logic [SELW-1:0]           sel_s   [NUM_SRC];
   logic [DATA_W-1:0]         opnd_s  [NUM_SRC];
   logic [NUM_SRC-1:0]        found_s;
   logic [NUM_SRC-1:0]        blk_s;
   logic [NUM_SRC*DATA_W-1:0] op_flat_s;
   logic [NUM_SRC*SELW-1:0]   sel_flat_s;

   logic                      hazard_s;
   logic                      ready_s;
   logic                      accept_s;

   // execute-stage register
   logic                      ex_valid_r;
   logic [NUM_SRC*DATA_W-1:0] ex_op_r;
   logic [REG_AW-1:0]         ex_rd_r;
   logic                      ex_we_r;
   logic [NUM_SRC*SELW-1:0]   fwd_sel_r;
   logic [15:0]               hazard_cnt_r;

   // Resolve every source independently: the lowest matching entry (youngest producer) wins, x0 never matches
   always_comb begin
      for (int s = 0; s < NUM_SRC; s++) begin
         rs_s[s]    = bus.id_rs_i[s*REG_AW +: REG_AW];
         sel_s[s]   = {SELW{1'b0}};
         opnd_s[s]  = bus.id_rf_data_i[s*DATA_W +: DATA_W];
         found_s[s] = 1'b0;
         blk_s[s]   = 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            if (!found_s[s] && (rs_s[s] != {REG_AW{1'b0}}) && sb_valid_r[k] &&
                sb_we_r[k] && (sb_rd_r[k] == rs_s[s])) begin
               found_s[s] = 1'b1;
               sel_s[s]   = SELW'(k + 1);
               opnd_s[s]  = bus.stg_data_i[k*DATA_W +: DATA_W];
               blk_s[s]   = !bus.stg_ready_i[k];
            end else begin
               found_s[s] = found_s[s];
            end
         end
      end
   end

   // Pack the per-source operands and select codes into the execute-register layout
   always_comb begin
      op_flat_s  = {(NUM_SRC*DATA_W){1'b0}};
      sel_flat_s = {(NUM_SRC*SELW){1'b0}};
      for (int s = 0; s < NUM_SRC; s++) begin
         op_flat_s[s*DATA_W +: DATA_W] = opnd_s[s];
         sel_flat_s[s*SELW +: SELW]    = sel_s[s];
      end
   end

   // Hazard only counts while decode really offers an instruction; hold beats everything
   always_comb begin
      hazard_s = bus.id_valid_i && (|blk_s);
      ready_s  = !bus.hold_i && !hazard_s;
      accept_s = bus.id_valid_i && ready_s;
   end

   // Scoreboard advance: shift toward WB on every non-held edge, oldest entry retires into the register file
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sb_valid_r <= {DEPTH{1'b0}};
         sb_we_r    <= {DEPTH{1'b0}};
         for (int k = 0; k < DEPTH; k++) begin
            sb_rd_r[k] <= {REG_AW{1'b0}};
         end
      end else if (!bus.hold_i) begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            sb_valid_r[k] <= sb_valid_r[k-1];
            sb_we_r[k]    <= sb_we_r[k-1];
            sb_rd_r[k]    <= sb_rd_r[k-1];
         end
         sb_valid_r[0] <= accept_s;
         sb_we_r[0]    <= accept_s && bus.id_we_i;
         sb_rd_r[0]    <= accept_s ? bus.id_rd_i : {REG_AW{1'b0}};
      end
   end

   // Execute register: load the accepted instruction with its resolved operands, otherwise insert a bubble
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_valid_r <= 1'b0;
         ex_op_r    <= {(NUM_SRC*DATA_W){1'b0}};
         ex_rd_r    <= {REG_AW{1'b0}};
         ex_we_r    <= 1'b0;
         fwd_sel_r  <= {(NUM_SRC*SELW){1'b0}};
      end else if (!bus.hold_i) begin
         if (accept_s) begin
            ex_valid_r <= 1'b1;
            ex_op_r    <= op_flat_s;
            ex_rd_r    <= bus.id_rd_i;
            ex_we_r    <= bus.id_we_i;
            fwd_sel_r  <= sel_flat_s;
         end else begin
            ex_valid_r <= 1'b0;
            ex_op_r    <= {(NUM_SRC*DATA_W){1'b0}};
            ex_rd_r    <= {REG_AW{1'b0}};
            ex_we_r    <= 1'b0;
            fwd_sel_r  <= {(NUM_SRC*SELW){1'b0}};
         end
      end
   end

   // Stall-cycle counter, saturating so a long stall can never wrap back to a small value
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hazard_cnt_r <= 16'h0000;
      end else if (hazard_s && !bus.hold_i && (hazard_cnt_r != 16'hFFFF)) begin
         hazard_cnt_r <= hazard_cnt_r + 16'd1;
      end
   end

   assign bus.id_ready_o   = ready_s;
   assign bus.ex_valid_o   = ex_valid_r;
   assign bus.ex_op_o      = ex_op_r;
   assign bus.ex_rd_o      = ex_rd_r;
   assign bus.ex_we_o      = ex_we_r;
   assign bus.fwd_sel_o    = fwd_sel_r;
   assign bus.hazard_cnt_o = hazard_cnt_r;

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Bench for fwd_operand_stage: directed scenarios plus random traffic. The driver
// computes the expected execute-register contents from a list of in-flight producers
// and queues them; a monitor pops one expectation per clock edge and compares.
module tb_fwd_operand_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fwd_operand_stage_if bus ();

   fwd_operand_stage dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic        v;
      logic [63:0] op;
      logic [3:0]  sel;
      logic [4:0]  rd;
      logic        we;
      logic [15:0] cnt;
   } exp_t;

   typedef struct packed {
      logic       v;
      logic       we;
      logic [4:0] rd;
   } ent_t;

   exp_t        exp_q[$];
   exp_t        last_exp;
   ent_t        flight[$];    // index 0 = most recently issued
   logic [15:0] m_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // stimulus state
   logic        in_v, in_we, in_hold;
   logic [4:0]  in_rs [2];
   logic [4:0]  in_rd;
   logic [31:0] in_rf [2];
   logic [31:0] in_sd [3];
   logic [2:0]  in_sr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      ent_t z;
      z = '0;
      flight.delete();
      repeat (3) flight.push_back(z);
      m_cnt    = 16'h0000;
      last_exp = '0;
      exp_q.delete();
   endtask

   // Drive one cycle, predict its outcome and queue the expectation for the coming edge
   task automatic step();
      exp_t        e;
      ent_t        ne;
      logic [1:0]  sel [2];
      logic [31:0] op  [2];
      logic        blocked, haz, rdy;
      @(negedge clk);
      bus.id_valid_i   = in_v;
      bus.id_rs_i      = {in_rs[1], in_rs[0]};
      bus.id_rf_data_i = {in_rf[1], in_rf[0]};
      bus.id_rd_i      = in_rd;
      bus.id_we_i      = in_we;
      bus.stg_data_i   = {in_sd[2], in_sd[1], in_sd[0]};
      bus.stg_ready_i  = in_sr;
      bus.hold_i       = in_hold;
      #1;
      blocked = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel[s] = 2'd0;
         op[s]  = in_rf[s];
         if (in_rs[s] != 5'd0) begin
            for (int k = 0; k < 3; k++) begin
               if (flight[k].v && flight[k].we && flight[k].rd == in_rs[s]) begin
                  sel[s] = 2'(k + 1);
                  op[s]  = in_sd[k];
                  if (!in_sr[k]) blocked = 1'b1;
                  break;
               end
            end
         end
      end
      haz = in_v && blocked;
      rdy = !in_hold && !haz;
      chk("id_ready", {63'd0, bus.id_ready_o}, {63'd0, rdy});
      if (in_hold) begin
         e = last_exp;
      end else begin
         if (haz && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         e = '0;
         if (in_v && rdy) begin
            e.v   = 1'b1;
            e.op  = {op[1], op[0]};
            e.sel = {sel[1], sel[0]};
            e.rd  = in_rd;
            e.we  = in_we;
         end
         e.cnt = m_cnt;
         ne.v  = in_v && rdy;
         ne.we = in_we;
         ne.rd = in_rd;
         flight.push_front(ne);
         void'(flight.pop_back());
         last_exp = e;
      end
      exp_q.push_back(e);
      @(posedge clk);
   endtask

   task automatic issue(input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [4:0] rd, input logic we);
      in_v     = 1'b1;
      in_rs[0] = rs0;
      in_rs[1] = rs1;
      in_rd    = rd;
      in_we    = we;
      step();
   endtask

   task automatic pulse_reset();
      #3 rst = 1'b1;
      #1;
      chk("rst_ex_valid", {63'd0, bus.ex_valid_o}, 64'd0);
      chk("rst_ex_op", bus.ex_op_o, 64'd0);
      chk("rst_ex_rd", {59'd0, bus.ex_rd_o}, 64'd0);
      chk("rst_ex_we", {63'd0, bus.ex_we_o}, 64'd0);
      chk("rst_fwd_sel", {60'd0, bus.fwd_sel_o}, 64'd0);
      chk("rst_hazard_cnt", {48'd0, bus.hazard_cnt_o}, 64'd0);
      rst = 1'b0;
      model_reset();
   endtask

   // Monitor: one expectation per clock edge, compared just after the edge
   initial begin : monitor
      exp_t m;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            chk("ex_valid", {63'd0, bus.ex_valid_o}, {63'd0, m.v});
            chk("ex_op", bus.ex_op_o, m.op);
            chk("fwd_sel", {60'd0, bus.fwd_sel_o}, {60'd0, m.sel});
            chk("hazard_cnt", {48'd0, bus.hazard_cnt_o}, {48'd0, m.cnt});
            if (m.v) begin
               chk("ex_rd", {59'd0, bus.ex_rd_o}, {59'd0, m.rd});
               chk("ex_we", {63'd0, bus.ex_we_o}, {63'd0, m.we});
            end
         end
      end
   end

   initial begin : driver
      int guard;
      in_v = 1'b0; in_we = 1'b0; in_hold = 1'b0; in_rd = 5'd0;
      in_rs[0] = 5'd0; in_rs[1] = 5'd0;
      in_rf[0] = 32'h0; in_rf[1] = 32'h0;
      in_sd[0] = 32'h0; in_sd[1] = 32'h0; in_sd[2] = 32'h0;
      in_sr = 3'b111;
      bus.id_valid_i = 1'b0; bus.id_rs_i = '0; bus.id_rf_data_i = '0;
      bus.id_rd_i = '0; bus.id_we_i = 1'b0; bus.stg_data_i = '0;
      bus.stg_ready_i = 3'b111; bus.hold_i = 1'b0;
      model_reset();
      #12;
      chk("init_ex_valid", {63'd0, bus.ex_valid_o}, 64'd0);
      chk("init_hazard_cnt", {48'd0, bus.hazard_cnt_o}, 64'd0);
      rst = 1'b0;

      // 1: reset mid-stream clears in-flight x5
      in_rf[0] = 32'hAAAA_0001; in_rf[1] = 32'hBBBB_0002;
      issue(5'd0, 5'd0, 5'd5, 1'b1);
      issue(5'd0, 5'd0, 5'd2, 1'b1);
      issue(5'd0, 5'd0, 5'd3, 1'b1);
      pulse_reset();
      in_rf[0] = 32'h1234_5678;
      issue(5'd5, 5'd0, 5'd4, 1'b1);
      #2;
      chk("t1_op0_rf", {32'd0, bus.ex_op_o[31:0]}, 64'h1234_5678);
      chk("t1_sel0", {62'd0, bus.fwd_sel_o[1:0]}, 64'd0);

      // 2: ALU back-to-back forward from EX
      issue(5'd0, 5'd0, 5'd5, 1'b1);
      in_sd[0] = 32'h11;
      issue(5'd5, 5'd0, 5'd1, 1'b1);
      #2;
      chk("t2_op0", {32'd0, bus.ex_op_o[31:0]}, 64'h11);
      chk("t2_sel0", {62'd0, bus.fwd_sel_o[1:0]}, 64'd1);

      // 3: load-use costs one bubble, then forwards from MEM
      issue(5'd0, 5'd0, 5'd6, 1'b1);
      in_sr = 3'b110;
      issue(5'd0, 5'd6, 5'd2, 1'b1);
      #2;
      chk("t3_bubble", {63'd0, bus.ex_valid_o}, 64'd0);
      chk("t3_cnt", {48'd0, bus.hazard_cnt_o}, 64'd1);
      in_sr = 3'b111;
      in_sd[1] = 32'hDEAD_0000;
      issue(5'd0, 5'd6, 5'd2, 1'b1);
      #2;
      chk("t3_op1", {32'd0, bus.ex_op_o[63:32]}, 64'hDEAD_0000);
      chk("t3_sel1", {62'd0, bus.fwd_sel_o[3:2]}, 64'd2);

      // 4: youngest producer of x7 wins, then x7 retires to the register file
      issue(5'd0, 5'd0, 5'd7, 1'b1);
      issue(5'd0, 5'd0, 5'd1, 1'b1);
      issue(5'd0, 5'd0, 5'd7, 1'b1);
      in_sd[0] = 32'hA; in_sd[2] = 32'hC;
      issue(5'd7, 5'd0, 5'd3, 1'b1);
      #2;
      chk("t4_op0_young", {32'd0, bus.ex_op_o[31:0]}, 64'hA);
      chk("t4_sel0_young", {62'd0, bus.fwd_sel_o[1:0]}, 64'd1);
      repeat (3) issue(5'd0, 5'd0, 5'd3, 1'b1);
      in_rf[0] = 32'h7777_0007;
      issue(5'd7, 5'd0, 5'd3, 1'b1);
      #2;
      chk("t4_op0_rf", {32'd0, bus.ex_op_o[31:0]}, 64'h7777_0007);
      chk("t4_sel0_rf", {62'd0, bus.fwd_sel_o[1:0]}, 64'd0);

      // 5: x0 never forwards; both sources may hit the same entry
      issue(5'd0, 5'd0, 5'd0, 1'b1);
      in_rf[0] = 32'h0101_0101; in_rf[1] = 32'h0202_0202;
      issue(5'd0, 5'd0, 5'd2, 1'b1);
      #2;
      chk("t5_x0_sel", {60'd0, bus.fwd_sel_o}, 64'd0);
      chk("t5_x0_op", bus.ex_op_o, 64'h0202_0202_0101_0101);
      issue(5'd0, 5'd0, 5'd9, 1'b1);
      in_sd[0] = 32'h55;
      issue(5'd9, 5'd9, 5'd2, 1'b1);
      #2;
      chk("t5_dual_sel", {60'd0, bus.fwd_sel_o}, 64'h5);
      chk("t5_dual_op", bus.ex_op_o, 64'h0000_0055_0000_0055);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         in_v     = ($urandom_range(0, 3) != 0);
         in_rs[0] = 5'($urandom_range(0, 7));
         in_rs[1] = 5'($urandom_range(0, 7));
         in_rd    = 5'($urandom_range(0, 7));
         in_we    = ($urandom_range(0, 3) != 0);
         in_rf[0] = $urandom; in_rf[1] = $urandom;
         in_sd[0] = $urandom; in_sd[1] = $urandom; in_sd[2] = $urandom;
         for (int k = 0; k < 3; k++) in_sr[k] = ($urandom_range(0, 3) != 0);
         in_hold  = ($urandom_range(0, 9) == 0);
         step();
      end
      in_hold = 1'b0;
      in_sr   = 3'b111;

      // 6: hold during a stall freezes everything, then the counter saturates
      pulse_reset();
      issue(5'd0, 5'd0, 5'd6, 1'b1);
      in_sr = 3'b110;
      issue(5'd6, 5'd0, 5'd6, 1'b1);
      in_hold = 1'b1;
      repeat (4) step();
      #2;
      chk("t6_hold_cnt", {48'd0, bus.hazard_cnt_o}, 64'd1);
      chk("t6_hold_valid", {63'd0, bus.ex_valid_o}, 64'd0);
      in_hold = 1'b0;
      in_sr   = 3'b000;
      guard   = 0;
      while (m_cnt != 16'hFFFF && guard < 90000) begin
         step();
         guard++;
      end
      repeat (8) step();
      #2;
      chk("t6_saturate", {48'd0, bus.hazard_cnt_o}, 64'hFFFF);

      #20;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
